// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: registered single-cycle ops plus iterative multu/divu into Hi/Lo.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for multu/divu; Start ignored while Ready=0.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] Src1,
  input  logic [WIDTH-1:0] Src2,
  input  logic [SHW-1:0]   shamt,
  input  logic [5:0]       funct,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Illegal
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0] F_ADDU  = 6'b001001;
  localparam logic [5:0] F_SUBU  = 6'b001010;
  localparam logic [5:0] F_NOR   = 6'b010011;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLTU  = 6'b101010;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic [1:0]       state_q, state_d;
  logic [SHW-1:0]   count_q, count_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign Ready   = (state_q != S_RUN);
  assign Done    = (state_q == S_DONE);
  assign Result  = result_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;
  assign Illegal = illegal_q;
  assign accept  = Start & Ready;

  // One iteration: multiply shifts {hi,lo} right after adding the multiplicand;
  // divide shifts the remainder left and restores when the trial subtract underflows.
  always_comb begin
    mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, op_q} : {(WIDTH+1){1'b0}});
    div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, op_q};
    if (is_div_q) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {work_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {work_lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], work_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    is_div_d  = is_div_q;
    op_d      = op_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    result_d  = result_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    illegal_d = 1'b0;

    if (state_q == S_RUN) begin
      work_hi_d = step_hi;
      work_lo_d = step_lo;
      count_d   = count_q - 1'b1;
      if (count_q == '0) begin
        state_d = S_DONE;
        hi_d    = step_hi;
        lo_d    = step_lo;
      end
    end else if (accept) begin
      state_d = S_DONE;
      case (funct)
        F_ADDU: result_d = Src1 + Src2;
        F_SUBU: result_d = Src1 - Src2;
        F_NOR:  result_d = ~(Src1 | Src2);
        F_OR:   result_d = Src1 | Src2;
        F_SLTU: result_d = {{(WIDTH-1){1'b0}}, (Src1 < Src2)};
        F_SRL:  result_d = Src2 >> shamt;
        F_MFHI: result_d = hi_q;
        F_MFLO: result_d = lo_q;
        F_MULTU, F_DIVU: begin
          state_d   = S_RUN;
          count_d   = SHW'(WIDTH - 1);
          is_div_d  = (funct == F_DIVU);
          op_d      = (funct == F_DIVU) ? Src2 : Src1;
          work_hi_d = '0;
          work_lo_d = (funct == F_DIVU) ? Src1 : Src2;
        end
        default: illegal_d = 1'b1;
      endcase
    end else begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      is_div_q  <= 1'b0;
      op_q      <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      result_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      is_div_q  <= is_div_d;
      op_q      <= op_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      result_q  <= result_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: expected outcomes queued at issue, compared when Done pulses.
module tb_alu_mc;
  localparam int W = 32;

  localparam logic [5:0] F_ADDU  = 6'b001001;
  localparam logic [5:0] F_SUBU  = 6'b001010;
  localparam logic [5:0] F_NOR   = 6'b010011;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLTU  = 6'b101010;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         Start = 1'b0;
  logic [W-1:0] Src1 = '0, Src2 = '0;
  logic [4:0]   shamt = '0;
  logic [5:0]   funct = '0;
  logic         Ready, Done, Illegal;
  logic [W-1:0] Result, Hi, Lo;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Src1(Src1), .Src2(Src2),
    .shamt(shamt), .funct(funct), .Ready(Ready), .Done(Done),
    .Result(Result), .Hi(Hi), .Lo(Lo), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         ill;
    int           lat;
    int           acc;
  } exp_t;

  exp_t         sb_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  logic [W-1:0] m_res = '0, m_hi = '0, m_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model: native wide arithmetic, applied in issue order.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] sh);
    exp_t        e;
    logic [63:0] prod;
    int          n = 0;
    while (!Ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!Ready) check_val("issue_timeout", 32'd0, 32'd1);
    Start = 1'b1; funct = f; Src1 = a; Src2 = b; shamt = sh;
    e.ill = 1'b0;
    e.lat = 0;
    case (f)
      F_ADDU:  m_res = a + b;
      F_SUBU:  m_res = a - b;
      F_NOR:   m_res = ~(a | b);
      F_OR:    m_res = a | b;
      F_SLTU:  m_res = (a < b) ? 32'd1 : 32'd0;
      F_SRL:   m_res = b >> sh;
      F_MFHI:  m_res = m_hi;
      F_MFLO:  m_res = m_lo;
      F_MULTU: begin
        prod = {32'd0, a} * {32'd0, b};
        m_hi = prod[63:32];
        m_lo = prod[31:0];
        e.lat = W;
      end
      F_DIVU: begin
        if (b == 0) begin
          m_lo = '1;
          m_hi = a;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
        e.lat = W;
      end
      default: e.ill = 1'b1;
    endcase
    e.res = m_res; e.hi = m_hi; e.lo = m_lo;
    e.acc = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!Done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!Done) check_val("done_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && Done) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("result", Result, e.res);
        check_val("hi", Hi, e.hi);
        check_val("lo", Lo, e.lo);
        check_val("illegal", {31'd0, Illegal}, {31'd0, e.ill});
        check_val("latency", cyc - e.acc, e.lat);
      end
    end
    if (!Done) check_val("illegal_without_done", {31'd0, Illegal}, 32'd0);
  end

  initial begin
    int k;
    int rdy0;
    #1;
    check_val("rst_result", Result, 32'd0);
    check_val("rst_hi", Hi, 32'd0);
    check_val("rst_lo", Lo, 32'd0);
    check_val("rst_done", {31'd0, Done}, 32'd0);
    check_val("rst_ready", {31'd0, Ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(F_ADDU, 32'hFFFF_FFFF, 32'd2, 5'd0);
    issue(F_SUBU, 32'd0, 32'd1, 5'd0);
    issue(F_SLTU, 32'd3, 32'hFFFF_FFFE, 5'd0);
    issue(F_NOR, 32'hF0F0_F0F0, 32'h0000_FFFF, 5'd0);
    issue(F_SRL, 32'd0, 32'h8000_0000, 5'd31);
    issue(F_OR, 32'h1234_0000, 32'h0000_5678, 5'd0);
    @(negedge clk);

    // Long multiply; a Start pulsed mid-RUN must not be accepted.
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    k = 0;
    rdy0 = 0;
    while (!Done && k < 100) begin
      if (!Ready) rdy0++;
      Start = (k == 5);
      funct = F_ADDU;
      @(negedge clk);
      k++;
    end
    Start = 1'b0;
    check_val("run_ready_low_cycles", rdy0, W);
    @(negedge clk);

    issue(F_DIVU, 32'd100, 32'd7, 5'd0);
    wait_done();
    @(negedge clk);
    issue(F_DIVU, 32'd5, 32'd0, 5'd0);
    wait_done();
    @(negedge clk);

    // Back-to-back: Mflo in Multu's DONE, then an illegal op in Mflo's DONE.
    issue(F_MULTU, 32'd6, 32'd7, 5'd0);
    wait_done();
    issue(F_MFLO, 32'd0, 32'd0, 5'd0);
    issue(6'b111111, 32'd9, 32'd9, 5'd0);
    issue(F_MFHI, 32'd0, 32'd0, 5'd0);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      logic [5:0] fs [6];
      fs = '{F_ADDU, F_SUBU, F_NOR, F_OR, F_SLTU, F_SRL};
      issue(fs[$urandom_range(0, 5)], $urandom, $urandom, 5'($urandom_range(0, 31)));
    end
    issue(F_DIVU, $urandom, 32'($urandom_range(1, 1000)), 5'd0);
    wait_done();
    issue(F_MFHI, 32'd0, 32'd0, 5'd0);
    @(negedge clk);

    // Abort a multiply in its tenth RUN cycle.
    issue(F_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    sb_q.delete();
    m_res = '0; m_hi = '0; m_lo = '0;
    check_val("abort_result", Result, 32'd0);
    check_val("abort_hi", Hi, 32'd0);
    check_val("abort_lo", Lo, 32'd0);
    check_val("abort_ready", {31'd0, Ready}, 32'd1);
    check_val("abort_done", {31'd0, Done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    issue(F_ADDU, 32'd1, 32'd1, 5'd0);

    k = 0;
    while (sb_q.size() > 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_val("scoreboard_drained", sb_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    check_val("final_ready", {31'd0, Ready}, 32'd1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
